// File: rtl/instr_encoder.sv
// instr_encoder: turns a stream of abstract commands into 32-bit instruction
// words, each tagged with the byte address where it is placed in the program.
// Illegal commands are consumed without emitting a word and are tallied in
// a sticky error flag plus a saturating error counter.
//
// Handshakes (both ports): a transfer happens on a rising edge where valid and
// ready are both high. A producer holding valid keeps its payload stable until
// that transfer. out_valid never depends on out_ready. in_ready is a function
// of the state and the output port only, never of in_valid.
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rn,
    input  logic [4:0]  in_rm,
    input  logic [25:0] in_imm,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  err_count,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] next_addr_q;
    logic        out_valid_q;
    logic [31:0] out_instr_q;
    logic [31:0] out_addr_q;
    logic        err_q;
    logic [7:0]  err_count_q;

    logic [31:0] instr_d;
    logic        legal_d;
    logic        accept;
    logic        out_xfer;

    // Immediate range predicates, written as "upper bits are a pure sign
    // extension" for signed fields and "upper bits are zero" for unsigned.
    logic        imm19_ok;
    logic        imm9_ok;
    logic        imm12u_ok;
    logic        imm18u_ok;

    assign imm19_ok  = (in_imm[25:18] == {8{in_imm[18]}});
    assign imm9_ok   = (in_imm[25:8] == {18{in_imm[8]}});
    assign imm12u_ok = (in_imm[25:12] == 14'd0);
    assign imm18u_ok = (in_imm[25:18] == 8'd0);

    assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_addr    = out_addr_q;
    assign err         = err_q;
    assign err_count   = err_count_q;
    assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);
    assign dbg_state_o = state_q;

    // Encode the command currently on the input port and judge its legality.
    always_comb begin
        instr_d = 32'h0000_0000;
        legal_d = 1'b1;
        case (in_op)
            4'd0: instr_d = {6'b000101, in_imm};
            4'd1: begin
                instr_d = {8'b01010100, in_imm[18:0], 5'b01011};
                legal_d = imm19_ok;
            end
            4'd2: begin
                instr_d = {8'b10110100, in_imm[18:0], in_rd};
                legal_d = imm19_ok;
            end
            4'd3: instr_d = {11'b10101011000, in_rm, 6'b000000, in_rn, in_rd};
            4'd4: instr_d = {11'b11101011000, in_rm, 6'b000000, in_rn, in_rd};
            4'd5: begin
                instr_d = {10'b1001000100, in_imm[11:0], in_rn, in_rd};
                legal_d = imm12u_ok;
            end
            4'd6: begin
                instr_d = {11'b00111000000, in_imm[8:0], 2'b00, in_rn, in_rd};
                legal_d = imm9_ok;
            end
            4'd7: begin
                instr_d = {11'b00111000010, in_imm[8:0], 2'b00, in_rn, in_rd};
                legal_d = imm9_ok;
            end
            4'd8: begin
                instr_d = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd};
                legal_d = imm9_ok;
            end
            4'd9: begin
                instr_d = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd};
                legal_d = imm9_ok;
            end
            4'd10: begin
                instr_d = {9'b110100101, in_imm[17:16], in_imm[15:0], in_rd};
                legal_d = imm18u_ok;
            end
            4'd11: begin
                instr_d = {9'b111100101, in_imm[17:16], in_imm[15:0], in_rd};
                legal_d = imm18u_ok;
            end
            4'd12: instr_d = 32'h0000_0000;
            default: legal_d = 1'b0;
        endcase
    end

    // Program-load FSM together with the output word register and error tally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            next_addr_q <= 32'h0;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            out_addr_q  <= 32'h0;
            err_q       <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_RUN;
                        next_addr_q <= base_addr;
                        err_q       <= 1'b0;
                        err_count_q <= 8'h00;
                    end
                end
                ST_RUN: begin
                    if (out_xfer) begin
                        out_valid_q <= 1'b0;
                    end
                    if (accept) begin
                        if (legal_d) begin
                            // A new word overrides the clear above: no bubble.
                            out_valid_q <= 1'b1;
                            out_instr_q <= instr_d;
                            out_addr_q  <= next_addr_q;
                            next_addr_q <= next_addr_q + 32'd4;
                        end else begin
                            err_q <= 1'b1;
                            if (err_count_q != 8'hFF) begin
                                err_count_q <= err_count_q + 8'd1;
                            end
                        end
                        if (in_last) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_xfer) begin
                        out_valid_q <= 1'b0;
                    end
                    if (!out_valid_q || out_xfer) begin
                        state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed scenarios plus a randomized stretch, with a
// scoreboard of {address, word} pairs predicted from an independent model.
module tb_instr_encoder;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rn;
    logic [4:0]  in_rm;
    logic [25:0] in_imm;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  err_count;
    logic [1:0]  dbg_state;

    instr_encoder dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rd       (in_rd),
        .in_rn       (in_rn),
        .in_rm       (in_rm),
        .in_imm      (in_imm),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_addr    (out_addr),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_count   (err_count),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [63:0] exp_q[$];
    logic [31:0] addr_model;
    int          err_model;
    int          n_checks;
    int          n_pass;
    logic [32:0] mon_r;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference encoder: legality from the numeric value of the immediate.
    function automatic logic [32:0] model_encode(input logic [3:0] op, input logic [4:0] rd,
                                                 input logic [4:0] rn, input logic [4:0] rm,
                                                 input logic [25:0] imm);
        logic [31:0] w;
        logic        ok;
        int          sv;
        sv = int'($signed({{6{imm[25]}}, imm}));
        w  = 32'h0;
        ok = 1'b1;
        case (op)
            4'd0: w = {6'b000101, imm};
            4'd1: begin w = {8'h54, imm[18:0], 5'd11}; ok = (sv >= -262144) && (sv <= 262143); end
            4'd2: begin w = {8'hB4, imm[18:0], rd}; ok = (sv >= -262144) && (sv <= 262143); end
            4'd3: w = {11'h558, rm, 6'd0, rn, rd};
            4'd4: w = {11'h758, rm, 6'd0, rn, rd};
            4'd5: begin w = {10'h244, imm[11:0], rn, rd}; ok = (imm < 26'd4096); end
            4'd6: begin w = {11'h1C0, imm[8:0], 2'b00, rn, rd}; ok = (sv >= -256) && (sv <= 255); end
            4'd7: begin w = {11'h1C2, imm[8:0], 2'b00, rn, rd}; ok = (sv >= -256) && (sv <= 255); end
            4'd8: begin w = {11'h7C0, imm[8:0], 2'b00, rn, rd}; ok = (sv >= -256) && (sv <= 255); end
            4'd9: begin w = {11'h7C2, imm[8:0], 2'b00, rn, rd}; ok = (sv >= -256) && (sv <= 255); end
            4'd10: begin w = {9'h1A5, imm[17:0], rd}; ok = (imm < 26'd262144); end
            4'd11: begin w = {9'h1E5, imm[17:0], rd}; ok = (imm < 26'd262144); end
            4'd12: w = 32'h0;
            default: ok = 1'b0;
        endcase
        return {ok, w};
    endfunction

    // Monitor: sampled on the falling edge, describing the transfers that
    // the next rising edge will perform.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra_word", {out_addr, out_instr}, 64'h0);
                end else begin
                    check("sb_word", {out_addr, out_instr}, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                mon_r = model_encode(in_op, in_rd, in_rn, in_rm, in_imm);
                if (mon_r[32]) begin
                    exp_q.push_back({addr_model, mon_r[31:0]});
                    addr_model = addr_model + 32'd4;
                end else if (err_model < 255) begin
                    err_model++;
                end
            end
        end
    end

    // ---------------- driver tasks (start and end at posedge + 1) ----------------
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic start_prog(input logic [31:0] base, input bit taken);
        start     = 1'b1;
        base_addr = base;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (taken) begin
            addr_model = base;
            err_model  = 0;
        end
    endtask

    task automatic send_cmd(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                            input logic [4:0] rm, input logic [25:0] imm, input logic last);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rn    = rn;
        in_rm    = rm;
        in_imm   = imm;
        in_last  = last;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!got) check("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            idle_cycle();
        end
        check("done_reached", done, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks   = 0;
        n_pass     = 0;
        addr_model = 32'h0;
        err_model  = 0;
        start      = 1'b0;
        base_addr  = 32'h0;
        in_valid   = 1'b0;
        in_op      = 4'd0;
        in_rd      = 5'd0;
        in_rn      = 5'd0;
        in_rm      = 5'd0;
        in_imm     = 26'd0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        do_reset();

        // Reset state.
        check("rst_out_valid", out_valid, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_state", dbg_state, S_IDLE);

        // ADDS with one-cycle latency.
        start_prog(32'h100, 1'b1);
        check("run_state", dbg_state, S_RUN);
        check("run_busy", busy, 1);
        send_cmd(4'd3, 5'd3, 5'd1, 5'd2, 26'd0, 1'b0);
        check("adds_valid", out_valid, 1);
        check("adds_instr", out_instr, 32'hAB020023);
        check("adds_addr", out_addr, 32'h100);

        // B with widest immediate, then MOVZ; start in RUN must be ignored.
        send_cmd(4'd0, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 1'b0);
        check("b_instr", out_instr, 32'h17FFFFFF);
        check("b_addr", out_addr, 32'h104);
        start_prog(32'hDEAD0000, 1'b0);
        send_cmd(4'd10, 5'd5, 5'd0, 5'd0, 26'h2ABCD, 1'b0);
        check("movz_instr", out_instr, 32'hD2D579A5);
        check("movz_addr", out_addr, 32'h108);

        // Out-of-range CBZ, then an undefined opcode.
        send_cmd(4'd2, 5'd1, 5'd0, 5'd0, 26'h40000, 1'b0);
        check("cbz_no_valid", out_valid, 0);
        check("cbz_err", err, 1);
        check("cbz_err_count", err_count, 1);
        send_cmd(4'd14, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
        check("op14_err_count", err_count, 2);
        send_cmd(4'd12, 5'd9, 5'd9, 5'd9, 26'h155, 1'b0);
        check("nop_instr", out_instr, 32'h0);
        check("nop_addr", out_addr, 32'h10C);
        idle_cycle();

        // Backpressure: word held for three cycles, then back-to-back words.
        out_ready = 1'b0;
        send_cmd(4'd5, 5'd7, 5'd9, 5'd0, 26'hFFF, 1'b0);
        in_valid = 1'b1;
        in_op    = 4'd9;
        in_rd    = 5'd1;
        in_rn    = 5'd2;
        in_imm   = 26'h3FFFFF0;
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            check("hold_valid", out_valid, 1);
            check("hold_instr", out_instr, 32'h913FFD27);
            check("hold_addr", out_addr, 32'h110);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        send_cmd(4'd9, 5'd1, 5'd2, 5'd0, 26'h3FFFFF0, 1'b0);
        check("b2b_valid0", out_valid, 1);
        check("b2b_addr0", out_addr, 32'h114);
        send_cmd(4'd8, 5'd4, 5'd6, 5'd0, 26'd8, 1'b1);
        check("b2b_valid1", out_valid, 1);
        check("b2b_addr1", out_addr, 32'h118);
        check("drain_state", dbg_state, S_DRAIN);
        idle_cycle();
        check("done_flag", done, 1);
        check("done_busy", busy, 0);
        check("done_out_valid", out_valid, 0);
        check("done_in_ready", in_ready, 0);

        // Address wrap, restart clears errors, illegal D-type offset.
        start_prog(32'hFFFFFFFC, 1'b1);
        check("restart_err", err, 0);
        check("restart_err_count", err_count, 0);
        send_cmd(4'd7, 5'd3, 5'd4, 5'd0, 26'h3FFFFFB, 1'b0);
        check("wrap_addr0", out_addr, 32'hFFFFFFFC);
        send_cmd(4'd6, 5'd3, 5'd4, 5'd0, 26'h100, 1'b0);
        check("dtype_range_err", err_count, 1);
        send_cmd(4'd11, 5'd2, 5'd0, 5'd0, 26'h3FFFF, 1'b1);
        check("wrap_addr1", out_addr, 32'h0);
        wait_done();
        check("wrap_in_ready", in_ready, 0);
        start_prog(32'h40, 1'b1);
        check("start2_state", dbg_state, S_RUN);
        check("start2_err", err, 0);

        // Reset while a word is held.
        out_ready = 1'b0;
        send_cmd(4'd4, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
        check("pre_rst_valid", out_valid, 1);
        reset = 1'b1;
        idle_cycle();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_state", dbg_state, S_IDLE);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        reset     = 1'b0;
        out_ready = 1'b1;
        idle_cycle();

        // Random commands with random backpressure, then error saturation.
        start_prog(32'h2000, 1'b1);
        for (int i = 0; i < 60; i++) begin
            logic [25:0] imm;
            if ($urandom_range(0, 1) == 0) imm = 26'($signed(10'($urandom_range(0, 1023))));
            else imm = 26'($urandom_range(0, 32'h3FFFFFF));
            out_ready = ($urandom_range(0, 3) != 0);
            send_cmd(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)), imm, 1'b0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send_cmd(4'(13 + $urandom_range(0, 2)), 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
        end
        send_cmd(4'd12, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1);
        wait_done();
        check("err_sat", err_count, 8'd255);
        check("err_model", err_count, 64'(err_model));
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port start  in  1  begin a program load; samples base_addr.
REQ-004 SHALL have port base_addr  in  32  byte address of first emitted word.
REQ-005 SHALL have ports in_valid  in  1 and in_ready  out  1  command handshake.
REQ-006 SHALL have port in_op  in  4  opcode selector, legal values 0-12 per REQ-016.
REQ-007 SHALL have ports in_rd, in_rn, in_rm  in  5 each  register fields.
REQ-008 SHALL have ports in_imm  in  26  signed or unsigned immediate, and in_last  in  1  final command marker.
REQ-009 SHALL have ports out_valid  out  1 and out_ready  in  1  instruction-word handshake.
REQ-010 SHALL have ports out_instr  out  32  encoded word, and out_addr  out  32  its byte address.
REQ-011 SHALL have status ports busy  out  1, done  out  1, err  out  1 (sticky), and err_count  out  8.

Function
REQ-012 SHALL implement FSM IDLE, RUN, DRAIN, DONE; busy=1 in RUN or DRAIN; done=1 only in DONE.
REQ-013 SHALL, on start in IDLE or DONE: go to RUN, set next_addr=base_addr, clear err and err_count; start SHALL be ignored in RUN/DRAIN.
REQ-014 SHALL drive in_ready = (state==RUN) && (!out_valid || out_ready); accept = in_valid && in_ready.
REQ-015 SHALL, on legal accept, in the next cycle present out_valid=1, out_instr=encoding, out_addr=next_addr, and advance next_addr by 4 (32-bit wrap, 0xFFFFFFFC->0x00000000); latency exactly 1 cycle.
REQ-016 SHALL encode per op:
 - 0 B: {000101, imm[25:0]}.
 - 1 B.LT: {01010100, imm[18:0], 01011}.
 - 2 CBZ: {10110100, imm[18:0], rd}.
 - 3 ADDS: {10101011000, rm, 000000, rn, rd}.
 - 4 SUBS: {11101011000, rm, 000000, rn, rd}.
 - 5 ADDI: {1001000100, imm[11:0], rn, rd}.
 - 6 STURB / 7 LDURB / 8 STUR / 9 LDUR: {00111000000 / 00111000010 / 11111000000 / 11111000010, imm[8:0], 00, rn, rd}.
 - 10 MOVZ / 11 MOVK: {110100101 / 111100101, imm[17:16], imm[15:0], rd}.
 - 12 NOP: 32'h00000000.
 - Fields unused by an op SHALL be ignored.
REQ-017 SHALL range-check immediates:
 - signed ops (B: none; B.LT, CBZ: imm[25:18] all equal imm[18]; D-type: imm[25:8] all equal imm[8]).
 - unsigned ops (ADDI: imm[25:12]==0; MOVZ/MOVK: imm[25:18]==0).
REQ-018 SHALL treat in_op 13-15 or a failed range check as illegal: command consumed, no word emitted, next_addr unchanged, err set to 1, err_count incremented, saturating at 255.
REQ-019 SHALL hold out_instr/out_addr stable while out_valid && !out_ready.
REQ-020 SHALL clear out_valid after an output handshake unless a legal accept occurs the same cycle, in which case the new word loads with no bubble.
REQ-021 SHALL move RUN->DRAIN when a command with in_last=1 is accepted, legal or not.
REQ-022 SHALL move DRAIN->DONE in the cycle out_valid==0 or an output handshake occurs; out_valid SHALL never assert in DONE or IDLE.

Reset
REQ-023 SHALL, on reset, enter IDLE with out_valid=0, out_instr=0, out_addr=0, next_addr=0, in_ready=0, busy=0, done=0, err=0, err_count=0; reset SHALL override start and any pending handshake, discarding a held word.

Verification
REQ-024 SHALL verify the following directed scenarios:
 - reset; start, base_addr=0x100; ADDS rd=3 rn=1 rm=2 -> next cycle out_valid=1, out_instr=0xAB020023, out_addr=0x100.
 - B imm=0x3FFFFFF -> out_instr=0x17FFFFFF; MOVZ rd=5 imm=0x2ABCD -> out_instr=0xD2D579A5 at following address.
 - CBZ imm=0x40000 -> no out_valid, err=1, err_count=1, next legal word uses unchanged address; op=14 -> err_count=2.
 - out_ready low 3 cycles with word held -> out_instr/out_addr stable, in_ready=0; out_ready high with in_valid high -> back-to-back words, no bubble.
 - base_addr=0xFFFFFFFC, two legal commands, second in_last=1 -> out_addr 0xFFFFFFFC then 0x00000000; done=1, in_ready=0; start -> RUN, err=0.
 - reset while out_valid=1 and out_ready=0 -> next cycle out_valid=0, state IDLE, busy=0, in_ready=0.
